// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: scans two WIDTH-bit operands MSB-first, one bit per clock,
// stopping at the first differing bit; unsigned or two's-complement selected per request.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CNT_W-1:0] cycles
);

    localparam int               IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [IDX_W-1:0] r_idx;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;
    logic [CNT_W-1:0] r_cycles;

    logic w_accept;
    logic w_bit_a;
    logic w_bit_b;
    logic w_differ;
    logic w_last;
    logic w_at_sign;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_bit_a   = r_a[r_idx];
    assign w_bit_b   = r_b[r_idx];
    assign w_differ  = w_bit_a ^ w_bit_b;
    assign w_last    = (r_idx == '0);
    // A differing sign bit inverts the sense: the operand with the 1 is the negative one.
    assign w_at_sign = r_signed && (r_idx == MSB_IDX);

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_differ || w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_gt     <= 1'b0;
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
            r_cycles <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_gt     <= 1'b0;
                r_eq     <= 1'b0;
                r_lt     <= 1'b0;
                r_cycles <= '0;
            end else if (r_state == S_SHIFT) begin
                r_cycles <= r_cycles + CNT_W'(1);
                if (w_differ) begin
                    r_gt <= w_at_sign ? w_bit_b : w_bit_a;
                    r_lt <= w_at_sign ? w_bit_a : w_bit_b;
                end else if (w_last) begin
                    r_eq <= 1'b1;
                end
            end
        end
    end

    // NOTE: operand/index registers carry no reset; they are always loaded on accept before SHIFT reads them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= signed_mode;
            r_idx    <= MSB_IDX;
        end else if (r_state == S_SHIFT && !w_differ && !w_last) begin
            r_idx <= r_idx - IDX_W'(1);
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign gt     = r_gt;
    assign eq     = r_eq;
    assign lt     = r_lt;
    assign cycles = r_cycles;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator: WIDTH=8 directed scenarios plus an
// exhaustive WIDTH=2 sweep in both compare modes.
module tb_serial_magnitude_comparator;

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       sm8 = 1'b0;
    logic       busy8, done8, gt8, eq8, lt8;
    logic [3:0] cycles8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       sm2 = 1'b0;
    logic       busy2, done2, gt2, eq2, lt2;
    logic [1:0] cycles2;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8)) u_dut8 (
        .clk(clk), .n_rst(n_rst), .start(start8), .a(a8), .b(b8), .signed_mode(sm8),
        .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8), .cycles(cycles8)
    );

    serial_magnitude_comparator #(.WIDTH(2)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .start(start2), .a(a2), .b(b2), .signed_mode(sm2),
        .busy(busy2), .done(done2), .gt(gt2), .eq(eq2), .lt(lt2), .cycles(cycles2)
    );

    // Reference: integer compare after optional sign extension; bits examined = w - (highest differing bit).
    function automatic exp_t model(input int w, input logic [7:0] x, input logic [7:0] y, input logic s);
        exp_t r;
        int   xi, yi;
        xi = int'(x);
        yi = int'(y);
        if (s && x[w-1]) xi = xi - (1 << w);
        if (s && y[w-1]) yi = yi - (1 << w);
        r.gt  = (xi > yi);
        r.eq  = (xi == yi);
        r.lt  = (xi < yi);
        r.cyc = w;
        for (int i = 0; i < w; i++)
            if (x[i] != y[i]) r.cyc = w - i;
        return r;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy2 : busy8;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? done2 : done8;
    endfunction

    function automatic logic [2:0] cur_flags(input bit sel);
        return sel ? {gt2, eq2, lt2} : {gt8, eq8, lt8};
    endfunction

    function automatic int cur_cycles(input bit sel);
        return sel ? int'(cycles2) : int'(cycles8);
    endfunction

    task automatic drive(input bit sel, input logic [7:0] ta, input logic [7:0] tbv,
                         input logic s, input logic st);
        if (sel) begin
            a2 = ta[1:0]; b2 = tbv[1:0]; sm2 = s; start2 = st;
        end else begin
            a8 = ta; b8 = tbv; sm8 = s; start8 = st;
        end
    endtask

    // Pops the scoreboard entry for the compare in flight and checks flags, count and timing.
    task automatic score(input bit sel, input string tag);
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (cur_flags(sel) !== {e.gt, e.eq, e.lt}) begin
            errors++;
            $display("FAIL %s flags: got gt/eq/lt=%b want %b", tag, cur_flags(sel), {e.gt, e.eq, e.lt});
        end
        checks++;
        if (cur_cycles(sel) != e.cyc) begin
            errors++;
            $display("FAIL %s cycles: got %0d want %0d", tag, cur_cycles(sel), e.cyc);
        end
        checks++;
        if (!$onehot(cur_flags(sel))) begin
            errors++;
            $display("FAIL %s onehot: got gt/eq/lt=%b want exactly one set", tag, cur_flags(sel));
        end
    endtask

    task automatic run_op(input bit sel, input logic [7:0] ta, input logic [7:0] tbv,
                          input logic s, input string tag);
        exp_t e;
        int   n, busy_cnt;
        bit   seen;
        e = model(sel ? 2 : 8, ta, tbv, s);
        @(negedge clk);
        drive(sel, ta, tbv, s, 1'b1);
        sb.push_back(e);
        @(posedge clk); #1;
        drive(sel, ta, tbv, s, 1'b0);
        busy_cnt = cur_busy(sel) ? 1 : 0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 12) begin
            @(posedge clk); #1;
            n++;
            if (cur_busy(sel)) busy_cnt++;
            if (cur_done(sel)) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: got no done in %0d edges want done after %0d", tag, n, e.cyc);
            void'(sb.pop_front());
        end else begin
            score(sel, tag);
            checks++;
            if (n != e.cyc) begin
                errors++;
                $display("FAIL %s latency: got done after %0d edges want %0d", tag, n, e.cyc);
            end
            checks++;
            if (busy_cnt != e.cyc + 1) begin
                errors++;
                $display("FAIL %s busy_len: got %0d cycles want %0d", tag, busy_cnt, e.cyc + 1);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (cur_busy(sel) !== 1'b0 || cur_done(sel) !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: got busy=%b done=%b want 0/0", tag, cur_busy(sel), cur_done(sel));
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8, gt8, eq8, lt8, cycles8} !== 9'b0) begin
            errors++;
            $display("FAIL reset8: got busy/done/gt/eq/lt/cycles=%b want 0", {busy8, done8, gt8, eq8, lt8, cycles8});
        end
        checks++;
        if ({busy2, done2, gt2, eq2, lt2, cycles2} !== 7'b0) begin
            errors++;
            $display("FAIL reset2: got busy/done/gt/eq/lt/cycles=%b want 0", {busy2, done2, gt2, eq2, lt2, cycles2});
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_msb();
        run_op(1'b0, 8'h80, 8'h7F, 1'b0, "msb_unsigned");
    endtask

    task automatic test_signed();
        run_op(1'b0, 8'h80, 8'h7F, 1'b1, "signed_sign_bit");
        run_op(1'b0, 8'hFF, 8'hFE, 1'b1, "signed_m1_m2");
    endtask

    task automatic test_equal_and_hold();
        run_op(1'b0, 8'h5A, 8'h5A, 1'b0, "equal");
        run_op(1'b0, 8'h12, 8'h13, 1'b0, "lsb_lt");
        a8 = 8'hFF;
        b8 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({gt8, eq8, lt8} !== 3'b001 || cycles8 !== 4'd8) begin
            errors++;
            $display("FAIL hold: got gt/eq/lt=%b cycles=%0d want 001 cycles=8", {gt8, eq8, lt8}, cycles8);
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        dones = 0;
        @(negedge clk);
        drive(1'b0, 8'h40, 8'h00, 1'b0, 1'b1);
        sb.push_back(model(8, 8'h40, 8'h00, 1'b0));
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        if (done8) dones++;
        @(posedge clk); #1;
        if (done8) dones++;
        checks++;
        if (done8 !== 1'b1) begin
            errors++;
            $display("FAIL ignore_done: got done=%b want 1 two edges after accept", done8);
        end else begin
            score(1'b0, "ignore");
        end
        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        if (done8) dones++;
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_in_done: got busy=%b want 0", busy8);
        end
        @(posedge clk); #1;
        if (done8) dones++;
        checks++;
        if (busy8 !== 1'b0 || dones != 1) begin
            errors++;
            $display("FAIL ignore_single: got busy=%b dones=%0d want 0/1", busy8, dones);
        end
    endtask

    task automatic test_mid_reset();
        int dones;
        dones = 0;
        @(negedge clk);
        drive(1'b0, 8'h01, 8'h00, 1'b0, 1'b1);
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy8, done8, gt8, eq8, lt8, cycles8} !== 9'b0) begin
            errors++;
            $display("FAIL mid_reset: got busy/done/gt/eq/lt/cycles=%b want 0", {busy8, done8, gt8, eq8, lt8, cycles8});
        end
        n_rst = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (done8) dones++;
        end
        checks++;
        if (dones != 0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got dones=%0d busy=%b want 0/0", dones, busy8);
        end
        run_op(1'b0, 8'h01, 8'h00, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b0, 8'h80, 8'h00, 1'b0, 1'b1);
        sb.push_back(model(8, 8'h80, 8'h00, 1'b0));
        sb.push_back(model(8, 8'h80, 8'h00, 1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (done8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_done: got done=%b want 1", done8);
            void'(sb.pop_front());
        end else begin
            score(1'b0, "b2b_first");
        end
        @(posedge clk); #1;
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got busy=%b want 0", busy8);
        end
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_retrigger: got busy=%b want 1", busy8);
        end
        @(posedge clk); #1;
        checks++;
        if (done8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_done: got done=%b want 1", done8);
            void'(sb.pop_front());
        end else begin
            score(1'b0, "b2b_second");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width2_sweep();
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++)
                    run_op(1'b1, 8'(x), 8'(y), 1'(m), $sformatf("w2_m%0d_%0d_%0d", m, x, y));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_msb();
        test_signed();
        test_equal_and_hold();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_width2_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Parametrised, bit-serial successor to the team's fixed 2-bit greater-than comparator. It compares two WIDTH-bit operands MSB-first, one bit per clock, and terminates at the first differing bit. Comparison is unsigned or two's-complement, selected per request. Results are gt/eq/lt flags plus a count of bits examined. It sits behind a start/done handshake for use by sequencers that trade latency for area.

Parameters:
WIDTH, 8, operand width in bits; legal range is 2 or more.
CNT_W, $clog2(WIDTH+1), width of the cycles output; derived, do not override.

Ports:
clk  input  1  rising-edge clock
n_rst  input  1  reset; one clock, synchronous, active-low (asserted 0, sampled on rising clk edge)
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on start accept
b  input  WIDTH  operand B; captured on start accept
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured on start accept
busy  output  1  high in SHIFT and DONE; start is ignored while high
done  output  1  one-cycle pulse; results valid from this cycle
gt  output  1  A > B
eq  output  1  A == B
lt  output  1  A < B
cycles  output  CNT_W  number of bits examined, 1..WIDTH

Behaviour:
- Reset (n_rst=0 at a rising edge):
  - state goes to IDLE.
  - busy, done, gt, eq, lt and cycles all go to 0.
  - Reset overrides everything, including mid-operation; the in-flight compare is abandoned with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1: capture a, b and signed_mode; set idx=WIDTH-1; clear gt/eq/lt/cycles to 0; go to SHIFT.
- SHIFT, one bit per edge, at bit idx of the captured operands:
  - cycles increments by 1 on every SHIFT edge.
  - Bits differ, unsigned, or signed with idx<WIDTH-1: gt=A[idx], lt=B[idx]; go to DONE.
  - Bits differ, signed, idx==WIDTH-1 (sign bit): gt=B[idx], lt=A[idx]; go to DONE.
  - Bits equal and idx==0: eq=1; go to DONE.
  - Bits equal and idx>0: idx decrements; stay in SHIFT.
- DONE:
  - done=1 for exactly one cycle, then IDLE unconditionally.
  - start is not accepted in DONE.
- Latency: start accepted at edge E0, N = bits examined (1..WIDTH).
  - Result registers are written at edge E0+N.
  - done is high in the cycle after E0+N.
  - busy is high from E0 through the DONE cycle.
  - Minimum request-to-request spacing is N+2 edges.
- Result hold:
  - gt/eq/lt/cycles hold their values after done until the next start accept clears them.
  - Exactly one of gt/eq/lt is 1 whenever done=1.
- Input changes:
  - a, b and signed_mode changing while busy have no effect on the compare in flight.
  - start held high continuously re-triggers on the first IDLE edge after DONE.
- Boundaries:
  - Equal operands always take WIDTH cycles.
  - An MSB difference always takes 1 cycle.
  - Signed 0x80 vs 0x7F (WIDTH=8) resolves at the sign bit as lt.

Test Plan:
- WIDTH=8, unsigned, a=0x80, b=0x7F, start pulsed one cycle -> done exactly 2 cycles after start edge; gt=1, eq=0, lt=0, cycles=1; busy high for 2 cycles.
- WIDTH=8, signed_mode=1, a=0x80, b=0x7F -> lt=1, cycles=1. Then a=0xFF, b=0xFE signed -> gt=1, cycles=8 (-1 > -2).
- WIDTH=8, a=b=0x5A -> eq=1, cycles=8, done 9 cycles after accept. Then a=0x12, b=0x13 -> lt=1, cycles=8. Results hold until the next start.
- WIDTH=8, a=0x40, b=0x00 accepted; pulse start with a=0x00, b=0xFF during SHIFT and in DONE -> second request ignored; gt=1, cycles=2; single done pulse.
- WIDTH=8, start with a=0x01, b=0x00; drive n_rst=0 on the 4th SHIFT edge -> next edge busy=0, gt=eq=lt=0, cycles=0, no done. After release, a=0x01, b=0x00 -> gt=1, cycles=8.
- WIDTH=2, both modes, all 16 (a,b) pairs -> unsigned gt matches a>b on every pair; signed gt/eq/lt match $signed compare; exactly one flag set per done.
